pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage core. It drives the hold and kill controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three sources: memory wait, load-use hazard and taken jump. It owns the registered redirect handshake to the fetch unit and a memory-wait watchdog. It sits beside the pipeline registers in the core top level, between the decode, execute and memory stages.

## Interface
- TIMEOUT_CYCLES, 1023: consecutive memory-stall cycles after which timeout_err sets.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1_addr, id_rs2_addr  in  5  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads rs1 / rs2.
- ex_valid  in  1  the ID/EX output holds a live instruction.
- ex_is_load  in  1  the EX instruction is a load.
- ex_rd_addr  in  5  destination register of the EX instruction.
- ex_jump  in  1  the EX instruction resolves as a taken jump or branch.
- ex_jump_addr  in  32  target of that jump.
- mem_req  in  1  EX/MEM holds a valid load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- redirect_ready  in  1  fetch unit accepts the redirect.
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb  out  1  hold the PC / pipeline register this cycle.
- flush_if_id  out  1  clear the IF/ID valid bit; takes priority over stall_if_id.
- bubble_id_ex  out  1  force valid_in=0 into ID/EX.
- redirect_valid  out  1  registered redirect request.
- redirect_addr  out  32  registered redirect target.
- ctrl_state  out  2  current FSM state, for debug.
- timeout_err  out  1  sticky watchdog flag.
- stall_cycles  out  32  count of cycles with stall_pc=1; wraps.

## Operation
- mem_stall = mem_req & ~mem_ready.
- load_use = ex_valid & ex_is_load & ex_rd_addr!=0 & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
- jump_take = ex_valid & ex_jump & ~mem_stall & state!=REDIRECT_WAIT.
- FSM states: RUN=0, MEM_WAIT=1, REDIRECT_WAIT=2.
  - RUN: jump_take → REDIRECT_WAIT; otherwise mem_stall → MEM_WAIT.
  - MEM_WAIT: ~mem_stall & jump_take → REDIRECT_WAIT; ~mem_stall → RUN.
  - REDIRECT_WAIT: redirect_valid & redirect_ready → RUN, or → MEM_WAIT if mem_stall. A memory stall while waiting does not change state.
- stall_ex_mem = stall_mem_wb = stall_id_ex = mem_stall.
- bubble_id_ex = ~mem_stall & (load_use | jump_take | state==REDIRECT_WAIT).
- flush_if_id = ~mem_stall & (jump_take | state==REDIRECT_WAIT).
- stall_if_id = mem_stall | (load_use & ~jump_take).
- stall_pc = mem_stall | load_use | jump_take | state==REDIRECT_WAIT.
- Priority: mem_stall > jump_take > load_use. A jump kills the younger load-use instruction in ID.
- On jump_take: redirect_addr <= ex_jump_addr and redirect_valid <= 1. redirect_addr stays stable while redirect_valid is high.
- redirect_valid clears on the edge where redirect_valid & redirect_ready. redirect_ready is ignored while redirect_valid=0.
- Watchdog counter: increments every mem_stall cycle, clears when mem_stall=0, and saturates at TIMEOUT_CYCLES. It is $clog2(TIMEOUT_CYCLES+1) bits wide.
  - timeout_err sets when the count reaches TIMEOUT_CYCLES and stays set until reset.
- stall_cycles increments by 1 modulo 2^32 on each cycle with stall_pc=1.

## Timing
- Reset values: state RUN, redirect_valid 0, redirect_addr 0, watchdog 0, timeout_err 0, stall_cycles 0.
- Combinational outputs follow their equations with state=RUN during reset.
- Reset mid-operation drops any pending redirect immediately.
- Stall, flush and bubble outputs are combinational, valid in the same cycle as their inputs.
- Redirect latency: jump_take in cycle N → redirect_valid=1 from N+1. If redirect_ready is high in N+1, the controller returns to RUN at N+2.
- A jump held in EX during a memory stall fires in the first cycle with mem_ready=1.
- Load-use costs exactly one bubble cycle.

## Structure
- State encodings and TIMEOUT_CYCLES default go in the shared pipeline definitions package.
- One sub-module, mem_wait_timer, holds the watchdog counter and sticky timeout_err.
- Hazard equations and the FSM stay in pipeline_ctrl.

## Test plan
- Load-use: ex_is_load=1, ex_rd_addr=5, id_rs1_addr=5, id_uses_rs1=1 → one cycle of stall_pc=1, stall_if_id=1, bubble_id_ex=1. With ex_rd_addr=0 → no stall.
- Jump, fetch ready: ex_jump=1, ex_jump_addr=0x100, redirect_ready=1 → flush_if_id and bubble_id_ex in N; redirect_valid with addr 0x100 in N+1; RUN at N+2.
- Jump with 3-cycle memory stall: mem_req=1, mem_ready=0 for 3 cycles → all stalls high and no redirect. In the mem_ready cycle, jump_take fires and the controller enters REDIRECT_WAIT.
- Redirect backpressure: redirect_ready=0 for 4 cycles → redirect_valid and redirect_addr held, flush/bubble every cycle, stall_cycles advances by 5 (jump cycle plus 4 wait cycles).
- Jump plus load-use in the same cycle → stall_if_id=0, flush_if_id=1.
- Watchdog and reset: TIMEOUT_CYCLES=4 with mem_stall held 5 cycles → timeout_err set and sticky after mem_ready. Asserting rst in REDIRECT_WAIT clears redirect_valid and timeout_err asynchronously.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Holds the controller state encoding and the default memory-wait watchdog limit.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    MEM_WAIT      = 2'd1,
    REDIRECT_WAIT = 2'd2
  } ctrl_state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1023;

endpackage

// File: rtl/pipeline_ctrl_mem_wait_timer.sv
// Memory-wait watchdog: counts consecutive memory-stall cycles, saturating at
// TIMEOUT_CYCLES, and raises a sticky error when that limit is reached.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = pipeline_ctrl_pkg::TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_stall,
  output logic timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count;
    if (!mem_stall) begin
      count_next = '0;
    end else if (count != LIMIT) begin
      count_next = count + 1'b1;
    end
  end

  // The error latches on the same edge the counter reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      timeout_err <= 1'b0;
    end else begin
      count <= count_next;
      if (count_next == LIMIT) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage core: hazard detection,
// redirect handshake to fetch, stall accounting and the memory-wait watchdog.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_jump,
  input  logic [31:0] ex_jump_addr,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        redirect_ready,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        stall_mem_wb,
  output logic        flush_if_id,
  output logic        bubble_id_ex,
  output logic        redirect_valid,
  output logic [31:0] redirect_addr,
  output logic [1:0]  ctrl_state,
  output logic        timeout_err,
  output logic [31:0] stall_cycles
);

  ctrl_state_t state;
  ctrl_state_t state_next;
  logic        mem_stall;
  logic        load_use;
  logic        jump_take;
  logic        in_redirect;

  assign ctrl_state  = state;
  assign in_redirect = (state == REDIRECT_WAIT);

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_valid & ex_is_load & (ex_rd_addr != 5'd0) &
                     ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                      (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
  assign jump_take = ex_valid & ex_jump & ~mem_stall & ~in_redirect;

  // Priority is mem_stall > jump_take > load_use; a jump kills the ID instruction.
  assign stall_id_ex  = mem_stall;
  assign stall_ex_mem = mem_stall;
  assign stall_mem_wb = mem_stall;
  assign bubble_id_ex = ~mem_stall & (load_use | jump_take | in_redirect);
  assign flush_if_id  = ~mem_stall & (jump_take | in_redirect);
  assign stall_if_id  = mem_stall | (load_use & ~jump_take);
  assign stall_pc     = mem_stall | load_use | jump_take | in_redirect;

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (jump_take) state_next = REDIRECT_WAIT;
        else if (mem_stall) state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!mem_stall) state_next = jump_take ? REDIRECT_WAIT : RUN;
      end
      REDIRECT_WAIT: begin
        if (redirect_valid && redirect_ready) state_next = mem_stall ? MEM_WAIT : RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Redirect handshake: a transfer occurs on an edge where redirect_valid and
  // redirect_ready are both high; redirect_addr is frozen while valid is high
  // and redirect_ready is ignored while valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
    end else if (jump_take) begin
      redirect_valid <= 1'b1;
      redirect_addr  <= ex_jump_addr;
    end else if (redirect_valid && redirect_ready) begin
      redirect_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           stall_cycles <= '0;
    else if (stall_pc) stall_cycles <= stall_cycles + 32'd1;
  end

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .mem_stall  (mem_stall),
    .timeout_err(timeout_err)
  );

endmodule
